// File: rtl/inst_fetch.sv
// ---------------------------------------------------------------------------
// inst_fetch
//
// Instruction fetch unit for CPU1. It owns a small instruction memory and
// presents one 16-bit instruction at a time on INST. Each instruction is held
// valid for PHASES cycles so the CPU can step through its execution phases.
// A one-cycle FETCH slot sits between consecutive instructions. A fetched
// word of 16'hFFFF is a halt marker: fetching stops and 'halted' stays high
// until reset.
//
// Parameters
//   PHASES  number of cycles each instruction is held valid (1..8)
//   ADDR_W  instruction memory address width (2^ADDR_W words of 16 bits)
//
// Ports
//   clk         single clock; all state changes on the rising edge
//   res         synchronous active-high reset; memory contents survive it
//   run         start / continue fetching
//   stall       freezes phase, pc and INST while an instruction is held
//   jmp_en      jump request, honoured only on the last non-stalled phase
//   jmp_addr    jump target
//   prog_we     instruction memory write enable (works in every state)
//   prog_addr   instruction memory write address
//   prog_data   instruction memory write data
//   INST        registered instruction fed to the CPU
//   inst_valid  high while INST holds a valid instruction
//   pc          address of the current instruction
//   phase       hold-cycle index 0..PHASES-1
//   halted      high once a halt word has been fetched
// ---------------------------------------------------------------------------
module inst_fetch #(
  parameter int PHASES = 5,
  parameter int ADDR_W = 8
) (
  input  logic              clk,
  input  logic              res,
  input  logic              run,
  input  logic              stall,
  input  logic              jmp_en,
  input  logic [ADDR_W-1:0] jmp_addr,
  input  logic              prog_we,
  input  logic [ADDR_W-1:0] prog_addr,
  input  logic [15:0]       prog_data,
  output logic [15:0]       INST,
  output logic              inst_valid,
  output logic [ADDR_W-1:0] pc,
  output logic [2:0]        phase,
  output logic              halted
);

  localparam int          DEPTH      = 1 << ADDR_W;
  localparam logic [2:0]  LAST_PHASE = 3'(PHASES - 1);
  localparam logic [15:0] HALT_WORD  = 16'hFFFF;
  localparam logic [15:0] NOP_WORD   = 16'h0000;
  localparam logic [ADDR_W-1:0] PC_ONE = ADDR_W'(1);

  typedef enum logic [1:0] {
    IDLE,
    FETCH,
    HOLD,
    HALT
  } state_t;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [2:0]        phase_q, phase_d;
  logic [15:0]       inst_q, inst_d;
  logic              valid_q, valid_d;
  logic              halted_q, halted_d;

  logic [15:0]       mem_q [0:DEPTH-1];
  logic [15:0]       fetch_word;

  // Instruction memory write port. It has no reset so a program loaded before
  // (or during) reset is kept; writes are honoured in every FSM state.
  always_ff @(posedge clk) begin
    if (prog_we) begin
      mem_q[prog_addr] <= prog_data;
    end
  end

  // The read is sampled into inst_q on the FETCH edge, which gives the
  // one-cycle synchronous read. Because the write above lands on that same
  // edge, a same-address write during FETCH returns the old word.
  assign fetch_word = mem_q[pc_q];

  // Next-state and datapath logic. Every register holds by default; each
  // state only overrides what it changes.
  always_comb begin
    state_d  = state_q;
    pc_d     = pc_q;
    phase_d  = phase_q;
    inst_d   = inst_q;
    valid_d  = valid_q;
    halted_d = halted_q;

    case (state_q)
      IDLE: begin
        inst_d  = NOP_WORD;
        valid_d = 1'b0;
        phase_d = 3'd0;
        if (run) begin
          state_d = FETCH;
        end
      end

      FETCH: begin
        phase_d = 3'd0;
        if (fetch_word == HALT_WORD) begin
          // pc is left pointing at the halt word for debug visibility.
          inst_d   = NOP_WORD;
          valid_d  = 1'b0;
          halted_d = 1'b1;
          state_d  = HALT;
        end else begin
          inst_d  = fetch_word;
          valid_d = 1'b1;
          state_d = HOLD;
        end
      end

      HOLD: begin
        if (!stall) begin
          if (phase_q < LAST_PHASE) begin
            phase_d = phase_q + 3'd1;
          end else begin
            // Last phase: the only point where a jump is taken. INST keeps
            // its value through FETCH but is cleared to NOP when going idle.
            pc_d    = jmp_en ? jmp_addr : (pc_q + PC_ONE);
            phase_d = 3'd0;
            valid_d = 1'b0;
            if (run) begin
              state_d = FETCH;
            end else begin
              inst_d  = NOP_WORD;
              state_d = IDLE;
            end
          end
        end
      end

      HALT: begin
        // Absorbing until reset; all control inputs are ignored.
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State register with synchronous reset that overrides everything else.
  always_ff @(posedge clk) begin
    if (res) begin
      state_q  <= IDLE;
      pc_q     <= '0;
      phase_q  <= 3'd0;
      inst_q   <= NOP_WORD;
      valid_q  <= 1'b0;
      halted_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      phase_q  <= phase_d;
      inst_q   <= inst_d;
      valid_q  <= valid_d;
      halted_q <= halted_d;
    end
  end

  assign INST       = inst_q;
  assign inst_valid = valid_q;
  assign pc         = pc_q;
  assign phase      = phase_q;
  assign halted     = halted_q;

endmodule

// File: tb/tb_inst_fetch.sv
// ---------------------------------------------------------------------------
// tb_inst_fetch
//
// Testbench for inst_fetch. A behavioural model tracks the fetch unit as
// "mode + cycles left in the current instruction" and is stepped with the
// same inputs the DUT sees; every cycle the DUT outputs are compared with it.
// A table of vectors covers the basic program flow with literal expected
// values, hand-written sequences cover stall, jump, wrap, reset and
// read-before-write corners, and a random run finishes off.
// ---------------------------------------------------------------------------
module tb_inst_fetch;

  localparam int PHASES = 5;
  localparam int ADDR_W = 8;

  localparam int MODE_IDLE  = 0;
  localparam int MODE_FETCH = 1;
  localparam int MODE_HOLD  = 2;
  localparam int MODE_HALT  = 3;

  logic        clk;
  logic        res;
  logic        run;
  logic        stall;
  logic        jmp_en;
  logic [7:0]  jmp_addr;
  logic        prog_we;
  logic [7:0]  prog_addr;
  logic [15:0] prog_data;
  logic [15:0] INST;
  logic        inst_valid;
  logic [7:0]  pc;
  logic [2:0]  phase;
  logic        halted;

  int tests;
  int fails;
  int cycleNum;

  // Reference model state
  int          mMode;
  int          mHoldLeft;
  logic [7:0]  mPc;
  logic [15:0] mInst;
  logic        mValid;
  logic        mHalted;
  logic [15:0] mMem [0:255];

  typedef struct {
    logic        res;
    logic        run;
    logic        stall;
    logic        jmpEn;
    logic [7:0]  jmpAddr;
    logic [15:0] expInst;
    logic        expValid;
    logic [7:0]  expPc;
    logic [2:0]  expPhase;
    logic        expHalted;
  } vec_t;

  vec_t tbl [16];

  inst_fetch #(.PHASES(PHASES), .ADDR_W(ADDR_W)) dut (
    .clk        (clk),
    .res        (res),
    .run        (run),
    .stall      (stall),
    .jmp_en     (jmp_en),
    .jmp_addr   (jmp_addr),
    .prog_we    (prog_we),
    .prog_addr  (prog_addr),
    .prog_data  (prog_data),
    .INST       (INST),
    .inst_valid (inst_valid),
    .pc         (pc),
    .phase      (phase),
    .halted     (halted)
  );

  // Free-running clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic vec_t mkVec(logic r, logic rn, logic st, logic j,
                                 logic [7:0] ja, logic [15:0] ei, logic ev,
                                 logic [7:0] ep, logic [2:0] eph, logic eh);
    vec_t v;
    v.res = r; v.run = rn; v.stall = st; v.jmpEn = j; v.jmpAddr = ja;
    v.expInst = ei; v.expValid = ev; v.expPc = ep; v.expPhase = eph;
    v.expHalted = eh;
    return v;
  endfunction

  // Advance the model by one clock edge using the current inputs
  task automatic modelStep();
    logic [15:0] readWord;
    readWord = mMem[mPc];
    if (prog_we) mMem[prog_addr] = prog_data;
    if (res) begin
      mMode = MODE_IDLE; mHoldLeft = 0; mPc = 8'h00;
      mInst = 16'h0000; mValid = 1'b0; mHalted = 1'b0;
      return;
    end
    case (mMode)
      MODE_IDLE: if (run) mMode = MODE_FETCH;
      MODE_FETCH: begin
        if (readWord == 16'hFFFF) begin
          mInst = 16'h0000; mValid = 1'b0; mHalted = 1'b1; mMode = MODE_HALT;
        end else begin
          mInst = readWord; mValid = 1'b1; mHoldLeft = PHASES; mMode = MODE_HOLD;
        end
      end
      MODE_HOLD: begin
        if (!stall) begin
          if (mHoldLeft > 1) begin
            mHoldLeft = mHoldLeft - 1;
          end else begin
            mPc = jmp_en ? jmp_addr : 8'(mPc + 8'd1);
            mValid = 1'b0;
            if (run) mMode = MODE_FETCH;
            else begin mMode = MODE_IDLE; mInst = 16'h0000; end
          end
        end
      end
      default: ;
    endcase
  endtask

  // Compare all DUT outputs against the model
  task automatic checkOutput();
    logic [2:0] expPhase;
    expPhase = (mMode == MODE_HOLD) ? 3'(PHASES - mHoldLeft) : 3'd0;
    tests++;
    if (INST !== mInst || inst_valid !== mValid || pc !== mPc ||
        phase !== expPhase || halted !== mHalted) begin
      fails++;
      $display("[TB] FAIL model cyc%0d: got inst=%h v=%b pc=%h ph=%0d h=%b, want inst=%h v=%b pc=%h ph=%0d h=%b",
               cycleNum, INST, inst_valid, pc, phase, halted,
               mInst, mValid, mPc, expPhase, mHalted);
    end
  endtask

  task automatic expectEq(string name, logic [15:0] act, logic [15:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("[TB] FAIL %s: got %h, want %h", name, act, exp);
    end
  endtask

  // One clock: step model, take the edge, sample 1 time unit later
  task automatic cycle();
    modelStep();
    @(posedge clk);
    #1;
    cycleNum++;
    checkOutput();
  endtask

  task automatic cycles(int n);
    for (int i = 0; i < n; i++) cycle();
  endtask

  task automatic applyStimulus(input vec_t v, input int idx);
    res = v.res; run = v.run; stall = v.stall;
    jmp_en = v.jmpEn; jmp_addr = v.jmpAddr;
    cycle();
    tests++;
    if (INST !== v.expInst || inst_valid !== v.expValid || pc !== v.expPc ||
        phase !== v.expPhase || halted !== v.expHalted) begin
      fails++;
      $display("[TB] FAIL vec%0d: got inst=%h v=%b pc=%h ph=%0d h=%b, want inst=%h v=%b pc=%h ph=%0d h=%b",
               idx, INST, inst_valid, pc, phase, halted,
               v.expInst, v.expValid, v.expPc, v.expPhase, v.expHalted);
    end
  endtask

  // Write one word while holding reset (also checks writes at reset edges)
  task automatic progWord(logic [7:0] a, logic [15:0] d);
    res = 1'b1; prog_we = 1'b1; prog_addr = a; prog_data = d;
    cycle();
    prog_we = 1'b0;
  endtask

  initial begin
    tests = 0; fails = 0; cycleNum = 0;
    mMode = MODE_IDLE; mHoldLeft = 0; mPc = 8'h00; mInst = 16'h0000;
    mValid = 1'b0; mHalted = 1'b0;
    for (int i = 0; i < 256; i++) mMem[i] = 16'h0000;
    res = 1'b1; run = 1'b0; stall = 1'b0; jmp_en = 1'b0; jmp_addr = 8'h00;
    prog_we = 1'b0; prog_addr = 8'h00; prog_data = 16'h0000;

    // Reset state
    cycle();
    expectEq("reset_inst", INST, 16'h0000);
    expectEq("reset_pc", {8'h00, pc}, 16'h0000);
    expectEq("reset_valid_halted", {14'd0, inst_valid, halted}, 16'h0000);

    // Fill all memory with non-halt words so every fetch is defined
    for (int i = 0; i < 256; i++) begin
      logic [15:0] w;
      w = 16'($urandom);
      if (w == 16'hFFFF) w = 16'h7FFF;
      progWord(8'(i), w);
    end

    // Table-driven program: 1206, 1403, halt
    progWord(8'h00, 16'h1206);
    progWord(8'h01, 16'h1403);
    progWord(8'h02, 16'hFFFF);
    tbl[0]  = mkVec(1'b0,1'b1,1'b0,1'b0,8'h00, 16'h0000,1'b0,8'h00,3'd0,1'b0);
    tbl[1]  = mkVec(1'b0,1'b1,1'b0,1'b0,8'h00, 16'h1206,1'b1,8'h00,3'd0,1'b0);
    tbl[2]  = mkVec(1'b0,1'b1,1'b0,1'b0,8'h00, 16'h1206,1'b1,8'h00,3'd1,1'b0);
    tbl[3]  = mkVec(1'b0,1'b1,1'b0,1'b0,8'h00, 16'h1206,1'b1,8'h00,3'd2,1'b0);
    tbl[4]  = mkVec(1'b0,1'b1,1'b0,1'b0,8'h00, 16'h1206,1'b1,8'h00,3'd3,1'b0);
    tbl[5]  = mkVec(1'b0,1'b1,1'b0,1'b0,8'h00, 16'h1206,1'b1,8'h00,3'd4,1'b0);
    tbl[6]  = mkVec(1'b0,1'b1,1'b0,1'b0,8'h00, 16'h1206,1'b0,8'h01,3'd0,1'b0);
    tbl[7]  = mkVec(1'b0,1'b1,1'b0,1'b0,8'h00, 16'h1403,1'b1,8'h01,3'd0,1'b0);
    tbl[8]  = mkVec(1'b0,1'b1,1'b0,1'b0,8'h00, 16'h1403,1'b1,8'h01,3'd1,1'b0);
    tbl[9]  = mkVec(1'b0,1'b1,1'b0,1'b0,8'h00, 16'h1403,1'b1,8'h01,3'd2,1'b0);
    tbl[10] = mkVec(1'b0,1'b1,1'b0,1'b0,8'h00, 16'h1403,1'b1,8'h01,3'd3,1'b0);
    tbl[11] = mkVec(1'b0,1'b1,1'b0,1'b0,8'h00, 16'h1403,1'b1,8'h01,3'd4,1'b0);
    tbl[12] = mkVec(1'b0,1'b1,1'b0,1'b0,8'h00, 16'h1403,1'b0,8'h02,3'd0,1'b0);
    tbl[13] = mkVec(1'b0,1'b1,1'b0,1'b0,8'h00, 16'h0000,1'b0,8'h02,3'd0,1'b1);
    tbl[14] = mkVec(1'b0,1'b1,1'b1,1'b1,8'h55, 16'h0000,1'b0,8'h02,3'd0,1'b1);
    tbl[15] = mkVec(1'b1,1'b1,1'b0,1'b0,8'h00, 16'h0000,1'b0,8'h00,3'd0,1'b0);
    for (int i = 0; i < 16; i++) applyStimulus(tbl[i], i);

    // Stall for 3 cycles at phase 2; instruction spans 9 cycles
    progWord(8'h00, 16'h1111);
    progWord(8'h01, 16'h2222);
    progWord(8'h40, 16'h4040);
    progWord(8'h41, 16'h4141);
    progWord(8'hFF, 16'hABCD);
    res = 1'b0; run = 1'b1;
    cycles(4);
    expectEq("stall_pre_phase", {13'd0, phase}, 16'd2);
    stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      cycle();
      expectEq("stall_phase", {13'd0, phase}, 16'd2);
      expectEq("stall_inst", INST, 16'h1111);
    end
    stall = 1'b0;
    cycles(2);
    expectEq("stall_pc_hold", {8'h00, pc}, 16'h0000);
    cycle();
    expectEq("stall_pc_next", {8'h00, pc}, 16'h0001);

    // Jump at last phase taken; jump at phase 1 ignored
    cycles(5);
    jmp_en = 1'b1; jmp_addr = 8'h40;
    cycle();
    jmp_en = 1'b0;
    expectEq("jump_taken_pc", {8'h00, pc}, 16'h0040);
    cycle();
    expectEq("jump_target_inst", INST, 16'h4040);
    cycle();
    jmp_en = 1'b1; jmp_addr = 8'h10;
    cycle();
    jmp_en = 1'b0;
    cycles(3);
    expectEq("jump_ignored_pc", {8'h00, pc}, 16'h0041);

    // Wrap from 0xFF to 0x00
    cycles(5);
    jmp_en = 1'b1; jmp_addr = 8'hFF;
    cycle();
    jmp_en = 1'b0;
    cycle();
    expectEq("wrap_inst_ff", INST, 16'hABCD);
    cycles(5);
    expectEq("wrap_pc", {8'h00, pc}, 16'h0000);
    cycle();
    expectEq("wrap_inst_0", INST, 16'h1111);

    // Reset at phase 3, memory intact, then run dropped at phase 1
    cycles(3);
    expectEq("rst_pre_phase", {13'd0, phase}, 16'd3);
    res = 1'b1;
    cycle();
    res = 1'b0;
    expectEq("rst_inst", INST, 16'h0000);
    expectEq("rst_pc_valid", {7'd0, inst_valid, pc}, 16'h0000);
    cycles(2);
    expectEq("rerun_inst", INST, 16'h1111);
    cycle();
    run = 1'b0;
    cycles(4);
    expectEq("run_drop_pc", {8'h00, pc}, 16'h0001);
    expectEq("run_drop_inst", {INST[14:0], inst_valid}, 16'h0000);
    cycle();
    expectEq("idle_stays_pc", {8'h00, pc}, 16'h0001);

    // Write during FETCH of same address returns old data; refetch sees new
    run = 1'b1;
    cycle();
    prog_we = 1'b1; prog_addr = 8'h01; prog_data = 16'h7777;
    cycle();
    prog_we = 1'b0;
    expectEq("rbw_old", INST, 16'h2222);
    cycles(4);
    jmp_en = 1'b1; jmp_addr = 8'h01;
    cycle();
    jmp_en = 1'b0;
    cycle();
    expectEq("rbw_new", INST, 16'h7777);

    // Random run against the model
    for (int i = 0; i < 3000; i++) begin
      res      = ($urandom_range(0, 63) == 0);
      run      = ($urandom_range(0, 3) != 0);
      stall    = ($urandom_range(0, 3) == 0);
      jmp_en   = ($urandom_range(0, 2) == 0);
      jmp_addr = 8'($urandom);
      prog_we  = ($urandom_range(0, 7) == 0);
      prog_addr = 8'($urandom);
      prog_data = ($urandom_range(0, 15) == 0) ? 16'hFFFF : 16'($urandom);
      cycle();
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
